// File: rtl/cpu_pkg.sv
// cpu_pkg: shared next-PC select encodings and default PC vectors for the multi-cycle CPU
package cpu_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_ALU = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RAS = 2'b11;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0080;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic            peek,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [CW-1:0] cnt;
  logic do_push, do_pop, do_rep, err_n;
  always_comb begin
    empty = cnt == '0;
    full = cnt == CW'(DEPTH);
    top = mem[ptr];
    ptr_inc = ptr + PW'(1);
    ptr_dec = ptr - PW'(1);
    do_push = en & push & (~pop | empty);
    do_rep = en & push & pop & ~empty;
    do_pop = en & pop & ~push & ~empty;
    err_n = en & ((push & ~pop & full) | (pop & ~push & empty) | (peek & empty));
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      err <= err_n;
      if (do_push) begin
        mem[ptr_inc] <= wdata;
        ptr <= ptr_inc;
        if (!full) cnt <= cnt + CW'(1);
      end else if (do_rep) begin
        mem[ptr] <= wdata;
      end else if (do_pop) begin
        ptr <= ptr_dec;
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with prioritised next-PC mux, trap/EPC capture and a return-address stack
module pc_ras_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
  parameter int INC = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            PCWr,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] AluOutput,
  input  logic [XLEN-1:0] JumpTarget,
  input  logic            RasPush,
  input  logic            RasPop,
  input  logic            Trap,
  output logic [XLEN-1:0] curPC,
  output logic [XLEN-1:0] nextPC,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err,
  output logic            misaligned
);
  localparam logic [XLEN-1:0] MASK = XLEN'(INC - 1);
  logic [XLEN-1:0] seq, raw;
  always_comb begin
    seq = curPC + XLEN'(INC);
    raw = Trap ? TRAP_VEC :
          PCSrc == PCSRC_SEQ ? seq :
          PCSrc == PCSRC_ALU ? AluOutput :
          PCSrc == PCSRC_JMP ? JumpTarget :
          ras_empty ? seq : ras_top;
    misaligned = |(raw & MASK);
    nextPC = raw & ~MASK;
  end
  ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .CLK(CLK),
    .Reset(Reset),
    .en(PCWr & ~Trap),
    .push(RasPush),
    .pop(RasPop),
    .peek(PCSrc == PCSRC_RAS),
    .wdata(seq),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full),
    .err(ras_err)
  );
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      curPC <= RESET_VEC;
      epc <= '0;
    end else if (Trap) begin
      curPC <= TRAP_VEC;
      epc <= curPC;
    end else if (PCWr) begin
      curPC <= nextPC;
    end
  end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program-counter unit for the multi-cycle CPU. Holds the PC and computes the next PC from four sources plus a trap vector.
- Adds a hardware return-address stack (RAS) for call/return acceleration, an exception PC (EPC) capture register, and target-misalignment detection.
- Sits between the control FSM (PCWr, PCSrc, RAS controls, Trap) and instruction fetch (curPC).

Parameters:
XLEN, 32, PC/address width in bits
RESET_VEC, 32'h0000_0000, PC value after Reset
TRAP_VEC, 32'h0000_0080, PC loaded on Trap
INC, 4, sequential increment in bytes (power of two)
RAS_DEPTH, 4, RAS entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
PCWr  in  1  PC write enable from control FSM
PCSrc  in  2  next-PC select: 00 seq, 01 ALU, 10 jump, 11 RAS top
AluOutput  in  XLEN  branch target from ALU
JumpTarget  in  XLEN  absolute jump target
RasPush  in  1  call: push curPC+INC (qualified by PCWr)
RasPop  in  1  return: pop top (qualified by PCWr)
Trap  in  1  exception request, highest priority
curPC  out  XLEN  current instruction address
nextPC  out  XLEN  combinational next address
epc  out  XLEN  PC of the trapping instruction
ras_top  out  XLEN  current RAS top entry
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_err  out  1  registered 1-cycle pulse: pop/PCSrc=11 on empty, or push on full
misaligned  out  1  combinational: selected target[log2(INC)-1:0] != 0

Behaviour:
- Reset (async, any cycle, including mid-sequence): curPC=RESET_VEC, epc=0, RAS count=0, RAS pointer=0, ras_err=0, all RAS entries=0. Outputs are valid in the same cycle Reset asserts.
- nextPC is combinational and evaluated in priority order:
  - Trap: TRAP_VEC.
  - PCSrc=00: curPC+INC.
  - 01: AluOutput.
  - 10: JumpTarget.
  - 11: ras_top when RAS is non-empty; curPC+INC when empty.
  - All sums wrap modulo 2^XLEN.
- misaligned: flags the selected raw target. The low log2(INC) bits of nextPC are always forced to 0 before loading.
- PC update on rising CLK:
  - Trap=1: curPC<=TRAP_VEC and epc<=curPC, regardless of PCWr. RAS is untouched.
  - Else PCWr=1: curPC<=nextPC.
  - Else: hold.
- RAS is a circular buffer with top pointer and count (0..RAS_DEPTH). It is updated only when PCWr=1 and Trap=0:
  - Push only, not full: write curPC+INC at ptr+1; ptr++; count++.
  - Push only, full: overwrite oldest entry (ptr++ wraps); count stays RAS_DEPTH; ras_err pulse.
  - Pop only, non-empty: ptr--; count--.
  - Pop only, empty: no change; ras_err pulse.
  - Push and pop together, non-empty: overwrite top with curPC+INC; ptr and count unchanged.
  - Push and pop together, empty: treated as push.
- PCSrc=11 with RAS empty: ras_err pulses. The PCSrc=11 read and the pop in the same cycle use the pre-pop top.
- ras_top = entry[ptr]. It equals 0 when empty after reset; otherwise it holds a stale value and is valid only when !ras_empty.
- Latency: nextPC is 0-cycle combinational; curPC/RAS/epc update 1 cycle after the edge; ras_err is high for exactly the cycle after the offending edge.

Decomposition:
- Shared package cpu_pkg: PCSrc encoding constants (PCSRC_SEQ, PCSRC_ALU, PCSRC_JMP, PCSRC_RAS), RESET_VEC/TRAP_VEC defaults.
- One natural sub-module: ras_stack (circular stack with push/pop/full/empty/err), instantiated once.
- Next-PC mux and PC/EPC registers stay in pc_ras_unit.

Test Plan:
- Reset then 3 cycles PCWr=1, PCSrc=00 -> curPC 0,4,8,12; Reset asserted asynchronously mid-cycle -> curPC=0 immediately.
- At curPC=0x10: PCSrc=01, AluOutput=0x40, PCWr=1 -> curPC=0x40. AluOutput=0x42 -> misaligned=1, curPC=0x40. PCWr=0 -> curPC holds.
- Call/return at curPC=0x20: PCSrc=10, JumpTarget=0x100, RasPush -> curPC=0x100, ras_top=0x24. Then PCSrc=11 with RasPop -> curPC=0x24, ras_empty=1.
- Five pushes with RAS_DEPTH=4 -> ras_full=1, ras_err pulse on 5th, oldest lost. Four pops return the newest four in LIFO order; a 5th pop -> ras_err, and PCSrc=11 yields curPC+4.
- Trap at curPC=0x30 with PCWr=0 -> curPC=0x80, epc=0x30, RAS count unchanged. Trap with RasPush asserted -> no push.
- Simultaneous RasPush+RasPop at count=2, curPC=0x50 -> ras_top=0x54, count stays 2.
